// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: multi-digit BCD up/down counter with a time-multiplexed digit scanner.
// Define BCD_SCAN_BLANK_EN to turn off leading-zero digits (digit 0 is always lit).
module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int SCAN_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SCAN_W-1:0]   psc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] up_nxt;
    logic [4*DIGITS-1:0] dn_nxt;
    logic [4*DIGITS-1:0] ld_val;
    logic                all9;
    logic                all0;
    logic [3:0]          dv;
    logic [3:0]          lv;
    logic [3:0]          sel_nib;
    logic [DIGITS-1:0]   sel_dig;
    logic                hi_zero;
    logic                blank;

    // Ripple the "all lower digits at 9/0" enables to build both count directions and the load sanitiser
    always_comb begin
        up_nxt = '0;
        dn_nxt = '0;
        ld_val = '0;
        all9   = 1'b1;
        all0   = 1'b1;
        dv     = '0;
        lv     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dv = count[4*i +: 4];
            lv = load_val[4*i +: 4];
            up_nxt[4*i +: 4] = all9 ? ((dv == 4'd9) ? 4'd0 : dv + 4'd1) : dv;
            dn_nxt[4*i +: 4] = all0 ? ((dv == 4'd0) ? 4'd9 : dv - 4'd1) : dv;
            ld_val[4*i +: 4] = (lv > 4'd9) ? 4'd0 : lv;
            all9 = all9 & (dv == 4'd9);
            all0 = all0 & (dv == 4'd0);
        end
    end

    // Count register with clear > load > strobed count priority; carry marks a full wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            count <= '0;
            carry <= 1'b0;
        end else if (load) begin
            count <= ld_val;
            carry <= 1'b0;
        end else if (en && inc) begin
            count <= up ? up_nxt : dn_nxt;
            carry <= up ? all9 : all0;
        end else begin
            carry <= 1'b0;
        end
    end

    // Select the scanned nibble and, with blanking, detect a leading-zero slot
    always_comb begin
        sel_nib = '0;
        sel_dig = '0;
        hi_zero = 1'b1;
        blank   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero & (count[4*i +: 4] == 4'd0);
            if (idx == IW'(i)) begin
                sel_nib    = count[4*i +: 4];
                sel_dig[i] = 1'b1;
`ifdef BCD_SCAN_BLANK_EN
                blank      = hi_zero && (i != 0);
`endif
            end
        end
    end

    // Free-running prescaler steps the scan index; scanner outputs are registered from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            idx <= '0;
            bcd <= '0;
            dig <= '0;
        end else begin
            psc <= (psc == SCAN_W'(SCAN_DIV - 1)) ? '0 : psc + 1'b1;
            if (psc == SCAN_W'(SCAN_DIV - 1))
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            bcd <= sel_nib;
            dig <= blank ? '0 : sel_dig;
        end
    end

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the team's BCD-to-seven-segment decoder.
- Each scan slot presents one digit's BCD nibble on BCD and asserts the matching one-hot digit select on DIG.
- Only one decoder instance is needed for a DIGITS-wide display.

Parameters:
- DIGITS, 4: number of BCD digits. Legal range 1..8.
- SCAN_DIV, 1000: CLK cycles per scan slot. Minimum 2.
- SCAN_W, 10: width of the scan prescaler. Must satisfy 2^SCAN_W >= SCAN_DIV.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- CLR  input  1  synchronous clear of the count.
- LOAD  input  1  synchronous load of LOAD_VAL.
- LOAD_VAL  input  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- EN  input  1  count enable.
- UP  input  1  count direction: 1 = up, 0 = down.
- INC  input  1  count strobe, one CLK cycle wide.
- COUNT  output  4*DIGITS  packed BCD count, registered.
- CARRY  output  1  one-cycle pulse on wrap (carry out when counting up, borrow when counting down).
- BCD  output  4  nibble of the currently scanned digit; feeds the seven-segment decoder.
- DIG  output  DIGITS  one-hot digit select, active-high. Bit i selects digit i.

Behaviour:
- Interface: single clock CLK; reset RST_N is asynchronous and active-low. All state clears immediately when RST_N=0 and is released on the first CLK edge after RST_N=1.
- Reset values:
  - COUNT=0, CARRY=0, BCD=4'd0, DIG=0 (all digits off).
  - Scan prescaler=0, scan index=0.
- Count update priority, evaluated per CLK edge: CLR > LOAD > (EN & INC). When none applies, COUNT holds.
- CLR: COUNT<=0. CARRY<=0.
- LOAD:
  - Each nibble <=9 is loaded as given.
  - Any nibble >9 is loaded as 0. Other nibbles are unaffected.
  - CARRY<=0.
- Up count (EN & INC & UP):
  - Digit 0 increments.
  - Digit i (i>0) increments only when all lower digits are 9.
  - A digit at 9 that increments becomes 0.
  - All digits 9 -> all digits 0, with CARRY=1 in the following cycle only.
- Down count (EN & INC & ~UP):
  - Digit 0 decrements.
  - Digit i (i>0) decrements only when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
  - All digits 0 -> all digits 9, with CARRY=1.
- CARRY is high for exactly one cycle per wrap and 0 otherwise. Back-to-back INC strobes that wrap on consecutive cycles produce consecutive CARRY pulses.
- INC held high with EN=1 counts once per cycle; this is legal.
- Count latency: COUNT reflects a CLR, LOAD or INC one cycle after the CLK edge at which it was sampled.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 every cycle, independent of EN.
  - At terminal count it returns to 0 and the scan index advances 0 -> 1 -> ... -> DIGITS-1 -> 0.
- Scanner outputs:
  - BCD and DIG are registered each cycle from the current scan index and COUNT.
  - BCD = COUNT nibble[index]; DIG = 1<<index.
  - Resulting latency: 1 cycle from a COUNT or index change to BCD/DIG.
- The first cycle after reset release gives DIG=1 and BCD=digit 0.
- DIG is always one-hot after the first cycle, or all zero as permitted by the optional feature. It is never multi-hot.
- CLR, LOAD and INC do not disturb the scan prescaler or the scan index.
- DIGITS=1: the scan index stays at 0 and DIG=1 permanently after the first cycle.
- BCD never carries a nibble >9.

Optional Feature:
- Macro: BCD_SCAN_BLANK_EN.
- When defined: leading-zero blanking.
  - While scanning digit i, DIG is driven to 0 (digit off) when digit i and all higher digits are 0, for i>0. BCD still carries 0 in that slot.
  - Digit 0 is never blanked, so a count of 0 displays a single "0".
- When undefined: every digit is always displayed, including leading zeros.

Test Plan:
- Bench uses DIGITS=4, SCAN_DIV=4.
- Reset: assert RST_N=0 mid-count with COUNT=0x1234 -> immediately COUNT=0, DIG=0, BCD=0, CARRY=0. After release, DIG=0001, BCD=0 on the first edge.
- Up wrap: LOAD 0x9998, UP=1, two INC pulses -> COUNT=0x9999, then 0x0000, with CARRY=1 for exactly one cycle after the second INC.
- Down borrow: LOAD 0x1000, UP=0, one INC -> 0x0999, CARRY=0. LOAD 0x0000, one INC -> 0x9999, CARRY=1 for one cycle.
- Priority and sanitising: CLR=1, LOAD=1, INC=1 on the same cycle -> COUNT=0. Then LOAD_VAL=0x3A7F -> COUNT=0x3070.
- Scan: COUNT=0x4321 -> over 16 cycles DIG cycles 0001, 0010, 0100, 1000, holding each for 4 cycles, with BCD 1, 2, 3, 4 respectively. EN=0 does not stop the scan.
- Blanking (macro defined): COUNT=0x0050 -> DIG=0100 and DIG=1000 slots are blanked (DIG=0). Slot 1 shows BCD=5, slot 0 shows BCD=0. COUNT=0 -> only slot 0 is lit.
